// File: rtl/wb_port_arbiter_if.sv
// Write-port arbiter bus: pipeline writeback, FPU result
// handshake, register-file write and hazard outputs.
interface wb_port_arbiter_if;
  logic        int_wb_valid_i;
  logic [4:0]  int_rd_i;
  logic [31:0] int_wb_data_i;
  logic        fpu_valid_i;
  logic [4:0]  fpu_rd_i;
  logic [31:0] fpu_data_i;
  logic        fpu_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o;
  logic        stall_o;
  logic [31:0] pend_mask_o;
  logic        err_o;

  modport slave (
    input  int_wb_valid_i,
    input  int_rd_i,
    input  int_wb_data_i,
    input  fpu_valid_i,
    input  fpu_rd_i,
    input  fpu_data_i,
    output fpu_ready_o,
    output rf_we_o,
    output rf_addr_o,
    output rf_data_o,
    output stall_o,
    output pend_mask_o,
    output err_o
  );

  modport master (
    output int_wb_valid_i,
    output int_rd_i,
    output int_wb_data_i,
    output fpu_valid_i,
    output fpu_rd_i,
    output fpu_data_i,
    input  fpu_ready_o,
    input  rf_we_o,
    input  rf_addr_o,
    input  rf_data_o,
    input  stall_o,
    input  pend_mask_o,
    input  err_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Integer register-file write-port arbiter: pipeline first,
// FPU integer results buffered and drained into idle slots.
module wb_port_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  wb_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int NW = PW + 1;
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [4:0]    q_rd   [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [NW-1:0] count;
  logic [NW-1:0] count_nx;
  logic [CW-1:0] wait_q;
  logic [CW-1:0] wait_nx;

  logic          stall_q;
  logic          err_q;
  logic          we_q;
  logic [4:0]    addr_q;
  logic [31:0]   data_q;

  logic          full;
  logic          empty;
  logic          accept;
  logic          keep;
  logic          g_int;
  logic          g_head;
  logic          g_byp;
  logic          err_set;
  logic          push;
  logic          granted;
  logic [4:0]    g_rd;
  logic [31:0]   g_data;
  logic [31:0]   mask;

  assign full   = (count == NW'(DEPTH));
  assign empty  = (count == '0);
  assign accept = bus.fpu_valid_i && !full;
  assign keep   = accept && (bus.fpu_rd_i != 5'd0);

  // Grant priority: pipeline, forced bubble, FIFO head, bypass.
  always_comb begin
    g_int   = 1'b0;
    g_head  = 1'b0;
    g_byp   = 1'b0;
    err_set = 1'b0;
    unique case (1'b1)
      (bus.int_wb_valid_i && !stall_q): g_int = 1'b1;
      stall_q: begin
        g_head  = !empty;
        err_set = bus.int_wb_valid_i;
      end
      (!bus.int_wb_valid_i && !stall_q && !empty):
        g_head = 1'b1;
      (!bus.int_wb_valid_i && !stall_q && empty && keep):
        g_byp = 1'b1;
      default: ;
    endcase
  end

  assign push    = keep && !g_byp;
  assign granted = g_int || g_head || g_byp;

  // Granted write source mux.
  always_comb begin
    g_rd   = bus.fpu_rd_i;
    g_data = bus.fpu_data_i;
    if (g_int) begin
      g_rd   = bus.int_rd_i;
      g_data = bus.int_wb_data_i;
    end else if (g_head) begin
      g_rd   = q_rd[rd_ptr];
      g_data = q_data[rd_ptr];
    end
  end

  // Next occupancy and head wait count.
  always_comb begin
    count_nx = count + NW'(push) - NW'(g_head);
    wait_nx  = wait_q;
    if (g_head || count_nx == '0)
      wait_nx = '0;
    else if (!empty && wait_q != CW'(MAX_WAIT))
      wait_nx = wait_q + CW'(1);
  end

  // Destinations still owed a write, plus one being accepted.
  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (NW'(i) < count)
        mask[q_rd[rd_ptr + PW'(i)]] = 1'b1;
    end
    if (keep)
      mask[bus.fpu_rd_i] = 1'b1;
  end

  // FIFO storage; contents are don't-care until counted valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_rd[wr_ptr]   <= bus.fpu_rd_i;
      q_data[wr_ptr] <= bus.fpu_data_i;
    end
  end

  // Pointers, counters, bubble request and error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      wait_q  <= '0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (g_head)
        rd_ptr <= rd_ptr + PW'(1);
      count   <= count_nx;
      wait_q  <= wait_nx;
      stall_q <= (count_nx != '0) &&
                 (wait_nx == CW'(MAX_WAIT));
      err_q   <= err_q || err_set;
    end
  end

  // Register-file write port, one cycle after grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (granted) begin
      we_q   <= (g_rd != 5'd0);
      addr_q <= g_rd;
      data_q <= g_data;
    end else begin
      we_q   <= 1'b0;
    end
  end

  assign bus.fpu_ready_o = !full;
  assign bus.rf_we_o     = we_q;
  assign bus.rf_addr_o   = addr_q;
  assign bus.rf_data_o   = data_q;
  assign bus.stall_o     = stall_q;
  assign bus.pend_mask_o = mask;
  assign bus.err_o       = err_q;
endmodule
